l1_line_responder: RTL and testbench

- Responder end of the L1 line-fill/writeback interface: accepts line-wide read/write requests issued by an L1 cache controller (pmem_* side) and serves them over a narrower beat-burst port to the physical memory / next level.
- Holds each line in an internal buffer; splits writebacks into beats and assembles fills from beats.
- Answers with a single-cycle pmem_resp per request.

---
 rtl/l1_line_responder.sv | 109 ++++++++++
 tb/tb_l1_line_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_responder.sv
// Line-wide L1 fill/writeback responder: buffers one cache line and moves it
// to or from the next level as a burst of narrower beats.
module l1_line_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int unsigned NBEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W  = $clog2(NBEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NBEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRBurst,
        StWBurst,
        StResp
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        pmem_resp   = 1'b0;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        burst_wdata = '0;

        case (state_q)
            StIdle: begin
                // Write takes priority; a simultaneous read must be re-presented.
                if (pmem_write) begin
                    addr_d  = pmem_address & ~OFF_MASK;
                    buf_d   = pmem_wdata;
                    cnt_d   = '0;
                    state_d = StWBurst;
                end else if (pmem_read) begin
                    addr_d  = pmem_address & ~OFF_MASK;
                    cnt_d   = '0;
                    state_d = StRBurst;
                end
            end
            StWBurst: begin
                burst_write = 1'b1;
                burst_wdata = buf_q[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH];
                if (burst_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = StResp;
                end
            end
            StRBurst: begin
                burst_read = 1'b1;
                if (burst_resp) begin
                    buf_d[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH] = burst_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = StResp;
                end
            end
            StResp: begin
                // Request lines are not sampled here, so a held request is served once.
                pmem_resp = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pmem_rdata    = buf_q;
    assign burst_address = addr_q;

endmodule

// File: tb/tb_l1_line_responder.sv
// Directed bench for l1_line_responder: a beat-serving memory model plus
// hand-computed expectations for reads, writes, priority, hold and reset.
module tb_l1_line_responder;

    logic         clk;
    logic         rst_n;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_wdata;
    logic [31:0]  burst_rdata;
    logic         burst_resp;

    logic [127:0] rd_line;
    int           mem_idx;
    int           n_cmp;
    int           n_bad;
    int           cyc;
    int           cnt_rd;
    int           cnt_resp;
    bit           rd_seen;
    bit           wr_seen;

    l1_line_responder #(
        .ADDR_WIDTH(16),
        .LINE_WIDTH(128),
        .BEAT_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: serves rd_line beat by beat, low beat first.
    always @(posedge clk) begin
        if (!rst_n || !burst_read) mem_idx <= 0;
        else if (burst_resp) mem_idx <= mem_idx + 1;
    end
    assign burst_rdata = rd_line[32*mem_idx +: 32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Current cycle counts as 1 (the IDLE accept); stops in the RESP cycle.
    task automatic wait_resp(output int n);
        n       = 1;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        while (!pmem_resp && n < 20) begin
            tick();
            n++;
            if (burst_read) rd_seen = 1'b1;
            if (burst_write) wr_seen = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] wbeats[4];
        wbeats = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        burst_resp   = 1'b0;
        rd_line      = '0;
        #12;
        check("rst_resp", pmem_resp, 0);
        check("rst_bread", burst_read, 0);
        check("rst_bwrite", burst_write, 0);
        check("rst_baddr", burst_address, 0);
        check("rst_rdata", pmem_rdata, 0);
        check("rst_wdata", burst_wdata, 0);
        rst_n = 1'b1;
        tick();

        // Read with burst_resp tied high.
        rd_line      = 128'h44444444_33333333_22222222_11111111;
        pmem_address = 16'h1234;
        pmem_read    = 1'b1;
        burst_resp   = 1'b1;
        tick();
        check("rd_baddr", burst_address, 16'h1230);
        check("rd_bread", burst_read, 1);
        wait_resp(cyc);
        cyc = cyc + 1;
        check("rd_latency", cyc, 6);
        check("rd_data", pmem_rdata, 128'h44444444_33333333_22222222_11111111);
        pmem_read = 1'b0;
        tick();
        check("rd_resp_1cyc", pmem_resp, 0);
        check("rd_data_hold", pmem_rdata, 128'h44444444_33333333_22222222_11111111);

        // Write with two stall cycles before each beat.
        pmem_address = 16'h0F0F;
        pmem_wdata   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        pmem_write   = 1'b1;
        burst_resp   = 1'b0;
        tick();
        check("wr_baddr", burst_address, 16'h0F00);
        check("wr_bwrite", burst_write, 1);
        check("wr_bread", burst_read, 0);
        for (int i = 0; i < 4; i++) begin
            burst_resp = 1'b0;
            check("wr_stall_a", burst_wdata, wbeats[i]);
            tick();
            check("wr_stall_b", burst_wdata, wbeats[i]);
            tick();
            burst_resp = 1'b1;
            check("wr_beat", burst_wdata, wbeats[i]);
            check("wr_no_resp", pmem_resp, 0);
            tick();
        end
        check("wr_resp", pmem_resp, 1);
        check("wr_resp_bwrite", burst_write, 0);
        pmem_write = 1'b0;
        burst_resp = 1'b0;
        tick();
        check("wr_resp_1cyc", pmem_resp, 0);
        check("wr_idle", burst_write, 0);

        // Read and write together: write first, read only after re-presentation.
        rd_line      = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909;
        pmem_address = 16'h4000;
        pmem_wdata   = 128'h87654321_0FEDCBA9_12345678_9ABCDEF0;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        burst_resp   = 1'b1;
        wait_resp(cyc);
        check("both_wr_seen", wr_seen, 1);
        check("both_rd_seen", rd_seen, 0);
        pmem_write = 1'b0;
        tick();
        wait_resp(cyc);
        check("both_rd_latency", cyc, 6);
        check("both_rd_seen2", rd_seen, 1);
        check("both_rd_data", pmem_rdata, 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909);

        // Read held through the response cycle: one burst, one response.
        // pmem_read is still high from the step above during this RESP cycle.
        tick();
        pmem_read = 1'b0;
        cnt_rd    = 0;
        cnt_resp  = 0;
        for (int i = 0; i < 8; i++) begin
            if (burst_read) cnt_rd++;
            if (pmem_resp) cnt_resp++;
            tick();
        end
        check("hold_no_reburst", cnt_rd, 0);
        check("hold_no_reresp", cnt_resp, 0);

        // Back-to-back write then read of the same line.
        pmem_address = 16'h2000;
        pmem_wdata   = 128'hFEEDFACE_CAFEBABE_DEADBEEF_01234567;
        pmem_write   = 1'b1;
        wait_resp(cyc);
        check("b2b_wr_latency", cyc, 6);
        pmem_write = 1'b0;
        tick();
        rd_line   = 128'hFEEDFACE_CAFEBABE_DEADBEEF_01234567;
        pmem_read = 1'b1;
        wait_resp(cyc);
        check("b2b_rd_latency", cyc, 6);
        check("b2b_rd_data", pmem_rdata, 128'hFEEDFACE_CAFEBABE_DEADBEEF_01234567);
        pmem_read = 1'b0;
        tick();

        // Reset after two of four read beats.
        rd_line      = 128'h55555555_66666666_77777777_88888888;
        pmem_address = 16'h3456;
        pmem_read    = 1'b1;
        tick();
        tick();
        tick();
        check("mid_bread", burst_read, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bread", burst_read, 0);
        check("rst_mid_rdata", pmem_rdata, 0);
        check("rst_mid_resp", pmem_resp, 0);
        check("rst_mid_baddr", burst_address, 0);
        pmem_read = 1'b0;
        tick();
        tick();
        check("rst_hold_resp", pmem_resp, 0);
        rst_n = 1'b1;
        tick();
        rd_line   = 128'h99999999_AAAA5555_5555AAAA_12121212;
        pmem_read = 1'b1;
        tick();
        check("post_rst_baddr", burst_address, 16'h3450);
        wait_resp(cyc);
        cyc = cyc + 1;
        check("post_rst_latency", cyc, 6);
        check("post_rst_data", pmem_rdata, 128'h99999999_AAAA5555_5555AAAA_12121212);
        pmem_read = 1'b0;
        tick();
        check("post_rst_idle", pmem_resp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
